// File: rtl/fsm_rq_rdy_arb_if.sv
// Handshake bundle between the command sources, the round-robin arbiter and
// the downstream command-sender engine.
interface fsm_rq_rdy_arb_if #(
  parameter int CH_NUM = 4,
  parameter int ID_W   = 2
);
  logic [CH_NUM-1:0] REQ;
  logic              ACK;
  logic              DONE;
  logic [CH_NUM-1:0] READY;
  logic              REQUEST_LATCH;
  logic [ID_W-1:0]   REQ_ID;
  logic              BUSY;
  logic              TIMEOUT;

  // Sources plus engine side: drives requests and the engine handshake.
  modport master (
    output REQ, ACK, DONE,
    input  READY, REQUEST_LATCH, REQ_ID, BUSY, TIMEOUT
  );

  // Arbiter side.
  modport slave (
    input  REQ, ACK, DONE,
    output READY, REQUEST_LATCH, REQ_ID, BUSY, TIMEOUT
  );
endinterface

// File: rtl/fsm_rq_rdy_arb.sv
// Multi-channel request/ready arbiter: latches one request per channel and
// grants them round-robin to a shared engine, with a per-phase watchdog.
module fsm_rq_rdy_arb #(
  parameter int          CH_NUM = 4,
  parameter int          ID_W   = 2,
  parameter int unsigned TO_CYC = 1000
) (
  input logic             CLK,
  input logic             RESET_N,
  fsm_rq_rdy_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARB, WAIT_ACK, WAIT_DONE} state_t;

  localparam bit              WDOG_EN  = (TO_CYC != 0);
  localparam logic [15:0]     TO_LIM   = WDOG_EN ? 16'(TO_CYC - 1) : 16'd0;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(CH_NUM - 1);

  state_t            state;
  logic [CH_NUM-1:0] pend;
  logic [ID_W-1:0]   last;
  logic [15:0]       timer;
  logic              rel_vld;   // REQ_ID names a finished channel still owed READY

  logic [CH_NUM-1:0] cap;
  logic [CH_NUM-1:0] grant_oh;
  logic [CH_NUM-1:0] rel_oh;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              awaited;
  logic              expire;

  assign cap     = bus.REQ & bus.READY;
  assign awaited = (state == WAIT_ACK) ? bus.ACK : bus.DONE;
  assign expire  = WDOG_EN && (timer == TO_LIM) && !awaited;

  // Round-robin pick: k runs downwards so the nearest channel after `last`
  // is the final (winning) assignment.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    rel_oh    = '0;
    if (state == ARB) begin
      for (int k = CH_NUM; k >= 1; k--) begin
        for (int j = 0; j < CH_NUM; j++) begin
          if (pend[j] && (j == (int'(last) + k) % CH_NUM)) begin
            grant_vld   = 1'b1;
            grant_idx   = ID_W'(j);
            grant_oh    = '0;
            grant_oh[j] = 1'b1;
          end
        end
      end
    end
    if ((state == IDLE) && rel_vld) begin
      for (int j = 0; j < CH_NUM; j++) begin
        if (ID_W'(j) == bus.REQ_ID) rel_oh[j] = 1'b1;
      end
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch sees the pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= IDLE;
      pend              <= '0;
      last              <= LAST_RST;
      timer             <= '0;
      rel_vld           <= 1'b0;
      bus.READY         <= '1;
      bus.REQUEST_LATCH <= 1'b0;
      bus.REQ_ID        <= '0;
      bus.BUSY          <= 1'b0;
      bus.TIMEOUT       <= 1'b0;
    end else begin
      bus.TIMEOUT <= 1'b0;
      bus.READY   <= (bus.READY & ~cap) | rel_oh;
      pend        <= (pend | cap) & ~grant_oh;

      case (state)
        IDLE: begin
          rel_vld <= 1'b0;
          state   <= ARB;
        end
        ARB: begin
          if (grant_vld) begin
            bus.REQ_ID        <= grant_idx;
            last              <= grant_idx;
            bus.REQUEST_LATCH <= 1'b1;
            bus.BUSY          <= 1'b1;
            timer             <= '0;
            state             <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // DONE is deliberately ignored here, even alongside ACK.
          if (bus.ACK) begin
            bus.REQUEST_LATCH <= 1'b0;
            timer             <= '0;
            state             <= WAIT_DONE;
          end else if (expire) begin
            bus.TIMEOUT       <= 1'b1;
            bus.REQUEST_LATCH <= 1'b0;
            bus.BUSY          <= 1'b0;
            rel_vld           <= 1'b1;
            state             <= IDLE;
          end else if (WDOG_EN) begin
            timer <= timer + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.DONE) begin
            bus.BUSY <= 1'b0;
            rel_vld  <= 1'b1;
            state    <= IDLE;
          end else if (expire) begin
            bus.TIMEOUT       <= 1'b1;
            bus.REQUEST_LATCH <= 1'b0;
            bus.BUSY          <= 1'b0;
            rel_vld           <= 1'b1;
            state             <= IDLE;
          end else if (WDOG_EN) begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          bus.REQUEST_LATCH <= 1'b0;
          bus.BUSY          <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fsm_rq_rdy_arb.md
Name: fsm_rq_rdy_arb

Overview:
- Multi-channel successor of the single request/ready handshake FSM.
- Latches up to CH_NUM independent requests, each with its own READY.
- Grants one request at a time, round-robin, to a shared downstream engine through the REQUEST_LATCH / ACK / DONE handshake.
- Adds a per-transaction watchdog timeout. Sits between the command sources (frame, config, gclk) and the MBI5153 command-sender FSM.

Parameters:
- CH_NUM, 4: number of requesting channels, 2..16.
- ID_W, 2: width of REQ_ID; must satisfy 2^ID_W >= CH_NUM.
- TO_CYC, 1000: watchdog limit in clock cycles for each of WAIT_ACK and WAIT_DONE. 0 disables the watchdog. Maximum 65535; the counter is 16 bits.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- REQ  in  CH_NUM  per-channel request. A one-cycle pulse or a level; only sampled while that channel's READY=1.
- ACK  in  1  downstream engine has taken the granted request.
- DONE  in  1  downstream engine has finished the granted request.
- READY  out  CH_NUM  per-channel ready, registered.
- REQUEST_LATCH  out  1  request presented to the downstream engine, registered.
- REQ_ID  out  ID_W  index of the granted channel. Valid while REQUEST_LATCH=1 or BUSY=1.
- BUSY  out  1  a transaction is in WAIT_ACK or WAIT_DONE.
- TIMEOUT  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset values (RESET_N=0, asynchronous):
  - state=IDLE, READY=all ones, REQUEST_LATCH=0, REQ_ID=0, BUSY=0, TIMEOUT=0.
  - pend=0, last=CH_NUM-1, so channel 0 wins the first arbitration.
  - Reset mid-transaction aborts it; all pending requests are lost.
- Request capture (every state):
  - If REQ[i]=1 and READY[i]=1: pend[i]<=1 and READY[i]<=0 on the next edge.
  - REQ[i] while READY[i]=0 is ignored; no queuing beyond one request per channel.
  - Simultaneous REQ on several channels are all captured in the same cycle.
- States:
  - IDLE: for the channel just completed or timed out (REQ_ID), READY[REQ_ID]<=1 (skipped after reset). Go to ARB unconditionally. One cycle.
  - ARB: if pend==0, stay. Otherwise pick the first set pend bit searching last+1, last+2, ... modulo CH_NUM. Then: REQ_ID<=idx, last<=idx, pend[idx]<=0, REQUEST_LATCH<=1, BUSY<=1, timer<=0, go to WAIT_ACK.
  - WAIT_ACK: on ACK=1, REQUEST_LATCH<=0, timer<=0, go to WAIT_DONE. DONE in this state is ignored, including ACK and DONE in the same cycle: ACK is taken and DONE is dropped.
  - WAIT_DONE: on DONE=1, BUSY<=0, go to IDLE. ACK is ignored.
  - Any other encoding: go to IDLE with REQUEST_LATCH=0, BUSY=0.
- Watchdog:
  - In WAIT_ACK or WAIT_DONE with TO_CYC!=0, timer increments each cycle the awaited input is low.
  - When timer==TO_CYC-1 and the awaited input is still low: TIMEOUT<=1 for one cycle, REQUEST_LATCH<=0, BUSY<=0, go to IDLE.
  - The timed-out channel gets READY back in IDLE exactly as if DONE had arrived. No retry is attempted.
- Latency:
  - REQ accepted at edge t: pend set at t+1.
  - If the FSM is in ARB at t+1, REQUEST_LATCH=1 after edge t+2.
  - DONE sampled at edge d: state=IDLE after d; READY high after d+1.
  - Back-to-back grants are separated by IDLE+ARB, i.e. at least 2 cycles with REQUEST_LATCH=0.
- Fairness: a channel waits at most CH_NUM-1 other transactions once pend is set.
- READY[i] stays low from capture until its own transaction's IDLE cycle.

Test Plan:
- Single channel (CH_NUM=4, TO_CYC=0):
  - Stimulus: REQ[2] pulse at cycle 5, ACK at 9, DONE at 14.
  - Required: READY[2]=0 from 6; REQUEST_LATCH=1 on cycles 7–9 and 0 from 10; REQ_ID=2; BUSY=1 on cycles 7–14; READY[2]=1 from 16.
- Round-robin order:
  - Stimulus: REQ=4'b1111 at one cycle after reset; ACK and DONE answered 2 cycles after each grant.
  - Required: grant order 0,1,2,3. Then REQ[0] and REQ[3] together → 0 granted before 3 only if last=3.
- Ignore rules:
  - Stimulus: REQ[1] repeated while READY[1]=0 → exactly one transaction for channel 1.
  - Stimulus: ACK and DONE in the same cycle while in WAIT_ACK → state WAIT_DONE; a later DONE is needed to finish.
- Watchdog (TO_CYC=4):
  - Stimulus: grant with ACK never asserted.
  - Required: TIMEOUT pulses exactly once, 4 cycles after the state enters WAIT_ACK; REQUEST_LATCH=0; READY restored; the next pending channel is then granted.
- Reset mid-operation:
  - Stimulus: assert RESET_N=0 asynchronously during WAIT_DONE with 2 channels pending.
  - Required: outputs are at reset values immediately, with no clock edge needed; after release, no grant occurs without a new REQ.
- Generality (CH_NUM=5, ID_W=3):
  - Stimulus: all channels request.
  - Required: REQ_ID sequence 0..4 then wraps to 0; no grant with REQ_ID>4.
